// File: rtl/mem_arb_pkg.sv
// Shared encodings for the I/D memory arbiter: FSM states and requester ids.
`timescale 1ns/1ps
package mem_arb_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic REQ_I = 1'b0;
   localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the I-side and D-side requests.
`timescale 1ns/1ps
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic i_req_i,
   input  logic i_req_d,
   input  logic i_fair,
   input  logic i_last,
   output logic o_winner,
   output logic o_conflict
);

   // On a tie, fair mode hands the memory to whichever side was not served last.
   always_comb begin
      o_conflict = i_req_i & i_req_d;
      o_winner   = REQ_I;
      if (o_conflict) begin
         o_winner = (i_fair && (i_last == REQ_D)) ? REQ_I : REQ_D;
      end else if (i_req_d) begin
         o_winner = REQ_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one 64-bit line memory port between I-cache and D-cache miss paths,
// holding each transaction for MEM_LATENCY cycles and acking the winner for one cycle.
`timescale 1ns/1ps
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LATENCY = 4,
   parameter int FAIR        = 0,
   parameter int ADDR_W      = 16,
   parameter int LINE_W      = 64
)(
   input  logic              Clk,
   input  logic              Reset_N,
   input  logic              i_readM,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_ack,
   input  logic              d_readM,
   input  logic              d_writeM,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              m_readM,
   output logic              m_writeM,
   output logic [ADDR_W-1:0] m_address,
   inout  wire  [LINE_W-1:0] m_data,
   output logic              grant_i,
   output logic              grant_d,
   output logic [15:0]       conflict_count
);

   localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

   logic [1:0]        r_state;
   logic [3:0]        r_cnt;
   logic              r_winner;
   logic              r_last;
   logic              r_write;
   logic [ADDR_W-1:0] r_addr;
   logic [LINE_W-1:0] r_wdata;
   logic [LINE_W-1:0] r_i_rdata;
   logic [LINE_W-1:0] r_d_rdata;
   logic [15:0]       r_conflict;

   logic w_d_req;
   logic w_any_req;
   logic w_winner;
   logic w_conflict;
   logic w_owned;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign w_d_req   = d_readM | d_writeM;
   assign w_any_req = i_readM | w_d_req;

   mem_arb_pick u_pick (
      .i_req_i    (i_readM),
      .i_req_d    (w_d_req),
      .i_fair     (FAIR != 0),
      .i_last     (r_last),
      .o_winner   (w_winner),
      .o_conflict (w_conflict)
   );

   always_ff @(posedge Clk) begin
      if (!Reset_N) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_winner   <= REQ_I;
         r_last     <= REQ_I;
         r_write    <= 1'b0;
         r_addr     <= '0;
         r_i_rdata  <= '0;
         r_d_rdata  <= '0;
         r_conflict <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_state  <= ST_BUSY;
                  r_cnt    <= '0;
                  r_winner <= w_winner;
                  r_last   <= w_winner;
                  r_addr   <= (w_winner == REQ_D) ? d_address : i_address;
                  r_write  <= (w_winner == REQ_D) && d_writeM;
                  if (w_conflict) begin
                     r_conflict <= sat_inc16(r_conflict);
                  end
               end
            end
            ST_BUSY: begin
               // The last busy edge is where the memory's read data is valid.
               if (r_cnt == LAST_CNT) begin
                  r_state <= ST_DONE;
                  r_cnt   <= '0;
                  if (!r_write) begin
                     if (r_winner == REQ_D) r_d_rdata <= m_data;
                     else                   r_i_rdata <= m_data;
                  end
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Write data is pure datapath; it only reaches the bus while a write is busy.
   always_ff @(posedge Clk) begin
      if ((r_state == ST_IDLE) && w_any_req) begin
         r_wdata <= d_wdata;
      end
   end

   assign w_owned        = (r_state == ST_BUSY) || (r_state == ST_DONE);
   assign m_readM        = (r_state == ST_BUSY) && !r_write;
   assign m_writeM       = (r_state == ST_BUSY) && r_write;
   assign m_address      = r_addr;
   assign m_data         = ((r_state == ST_BUSY) && r_write) ? r_wdata : {LINE_W{1'bz}};
   assign grant_i        = w_owned && (r_winner == REQ_I);
   assign grant_d        = w_owned && (r_winner == REQ_D);
   assign i_ack          = (r_state == ST_DONE) && (r_winner == REQ_I);
   assign d_ack          = (r_state == ST_DONE) && (r_winner == REQ_D);
   assign i_rdata        = r_i_rdata;
   assign d_rdata        = r_d_rdata;
   assign conflict_count = r_conflict;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a fixed-priority and a round-robin instance share stimulus.
`timescale 1ns/1ps
module tb_mem_arbiter;

   logic        Clk;
   logic        Reset_N;
   logic        i_readM;
   logic [15:0] i_address;
   logic        d_readM;
   logic        d_writeM;
   logic [15:0] d_address;
   logic [63:0] d_wdata;

   logic [63:0] r_mem_val;
   logic        r_park;

   logic [63:0] i_rdata0, d_rdata0, i_rdata1, d_rdata1;
   logic        i_ack0, d_ack0, i_ack1, d_ack1;
   logic        m_readM0, m_writeM0, m_readM1, m_writeM1;
   logic [15:0] m_address0, m_address1;
   wire  [63:0] m_data0, m_data1;
   logic        grant_i0, grant_d0, grant_i1, grant_d1;
   logic [15:0] conflict0, conflict1;

   int n_checks;
   int n_err;

   // Memory model: drives read data during a read, or a parking pattern on request.
   assign m_data0 = (m_readM0 || r_park) ? r_mem_val : {64{1'bz}};
   assign m_data1 = (m_readM1 || r_park) ? r_mem_val : {64{1'bz}};

   mem_arbiter #(.MEM_LATENCY(4), .FAIR(0), .ADDR_W(16), .LINE_W(64)) u_dut0 (
      .Clk(Clk), .Reset_N(Reset_N),
      .i_readM(i_readM), .i_address(i_address), .i_rdata(i_rdata0), .i_ack(i_ack0),
      .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata0), .d_ack(d_ack0),
      .m_readM(m_readM0), .m_writeM(m_writeM0), .m_address(m_address0), .m_data(m_data0),
      .grant_i(grant_i0), .grant_d(grant_d0), .conflict_count(conflict0)
   );

   mem_arbiter #(.MEM_LATENCY(4), .FAIR(1), .ADDR_W(16), .LINE_W(64)) u_dut1 (
      .Clk(Clk), .Reset_N(Reset_N),
      .i_readM(i_readM), .i_address(i_address), .i_rdata(i_rdata1), .i_ack(i_ack1),
      .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata1), .d_ack(d_ack1),
      .m_readM(m_readM1), .m_writeM(m_writeM1), .m_address(m_address1), .m_data(m_data1),
      .grant_i(grant_i1), .grant_d(grant_d1), .conflict_count(conflict1)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      n_checks  = 0;
      n_err     = 0;
      Reset_N   = 1'b0;
      i_readM   = 1'b0;
      i_address = 16'h0000;
      d_readM   = 1'b0;
      d_writeM  = 1'b0;
      d_address = 16'h0000;
      d_wdata   = 64'h0;
      r_mem_val = 64'h0;
      r_park    = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_m_readM",   m_readM0, 0);
      chk("rst_m_writeM",  m_writeM0, 0);
      chk("rst_grant_i",   grant_i0, 0);
      chk("rst_grant_d",   grant_d0, 0);
      chk("rst_i_ack",     i_ack0, 0);
      chk("rst_d_ack",     d_ack0, 0);
      chk("rst_m_address", m_address0, 0);
      chk("rst_i_rdata",   i_rdata0, 0);
      chk("rst_d_rdata",   d_rdata0, 0);
      chk("rst_conflict",  conflict0, 0);
      Reset_N = 1'b1;
      tick();

      // I-only read of 0x0040
      r_mem_val = 64'h1111_2222_3333_4444;
      i_readM   = 1'b1;
      i_address = 16'h0040;
      tick();
      chk("t1_grant_i", grant_i0, 1);
      for (int k = 0; k < 4; k++) begin
         chk("t1_m_readM", m_readM0, 1);
         chk("t1_m_addr",  m_address0, 64'h0040);
         chk("t1_i_ack_busy", i_ack0, 0);
         tick();
      end
      chk("t1_m_readM_done", m_readM0, 0);
      chk("t1_i_ack",    i_ack0, 1);
      chk("t1_i_ack_f1", i_ack1, 1);
      chk("t1_d_ack",    d_ack0, 0);
      chk("t1_i_rdata",  i_rdata0, 64'h1111_2222_3333_4444);
      chk("t1_i_rdata_f1", i_rdata1, 64'h1111_2222_3333_4444);
      i_readM = 1'b0;
      tick();
      chk("t1_i_ack_off", i_ack0, 0);
      chk("t1_grant_off", grant_i0, 0);
      chk("t1_i_rdata_hold", i_rdata0, 64'h1111_2222_3333_4444);

      // Simultaneous I 0x0010 / D 0x0020 reads, fixed priority
      i_readM   = 1'b1;
      i_address = 16'h0010;
      d_readM   = 1'b1;
      d_address = 16'h0020;
      r_mem_val = 64'hAAAA_AAAA_0000_0020;
      tick();
      chk("t2_grant_d",  grant_d0, 1);
      chk("t2_grant_i",  grant_i0, 0);
      chk("t2_m_addr",   m_address0, 64'h0020);
      chk("t2_m_addr_f1", m_address1, 64'h0020);
      chk("t2_m_readM",  m_readM0, 1);
      repeat (4) tick();
      chk("t2_d_ack",    d_ack0, 1);
      chk("t2_i_ack",    i_ack0, 0);
      chk("t2_d_rdata",  d_rdata0, 64'hAAAA_AAAA_0000_0020);
      chk("t2_d_rdata_f1", d_rdata1, 64'hAAAA_AAAA_0000_0020);
      d_readM = 1'b0;
      tick();
      chk("t2_gap_grant_i", grant_i0, 0);
      chk("t2_gap_grant_d", grant_d0, 0);
      r_mem_val = 64'hBBBB_BBBB_0000_0010;
      tick();
      chk("t2_grant_i2", grant_i0, 1);
      chk("t2_m_addr2",  m_address0, 64'h0010);
      repeat (4) tick();
      chk("t2_i_ack2",   i_ack0, 1);
      chk("t2_i_rdata2", i_rdata0, 64'hBBBB_BBBB_0000_0010);
      i_readM = 1'b0;
      tick();
      chk("t2_conflict",    conflict0, 1);
      chk("t2_conflict_f1", conflict1, 1);

      // Continuous contention: round-robin alternates D,I,D,I; fixed priority keeps D
      Reset_N = 1'b0;
      tick();
      Reset_N = 1'b1;
      chk("t3_conflict_rst", conflict1, 0);
      r_mem_val = 64'hCCCC_CCCC_CCCC_CCCC;
      i_readM   = 1'b1;
      i_address = 16'h0010;
      d_readM   = 1'b1;
      d_address = 16'h0020;
      for (int t = 0; t < 4; t++) begin
         tick();
         chk("t3_rr_grant_d", grant_d1, (t % 2 == 0));
         chk("t3_rr_grant_i", grant_i1, (t % 2 == 1));
         chk("t3_fix_grant_d", grant_d0, 1);
         repeat (4) tick();
         chk("t3_rr_d_ack", d_ack1, (t % 2 == 0));
         chk("t3_rr_i_ack", i_ack1, (t % 2 == 1));
         tick();
      end
      i_readM = 1'b0;
      d_readM = 1'b0;
      chk("t3_conflict_f1",  conflict1, 4);
      chk("t3_conflict_fix", conflict0, 4);

      // D write of 0x0080; bus released outside BUSY
      r_mem_val = 64'h5A5A_5A5A_5A5A_5A5A;
      r_park    = 1'b1;
      #1;
      chk("t4_bus_idle", m_data0, 64'h5A5A_5A5A_5A5A_5A5A);
      r_park    = 1'b0;
      d_writeM  = 1'b1;
      d_address = 16'h0080;
      d_wdata   = 64'hDEAD_BEEF_0000_0001;
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("t4_m_writeM", m_writeM0, 1);
         chk("t4_m_readM",  m_readM0, 0);
         chk("t4_m_data",   m_data0, 64'hDEAD_BEEF_0000_0001);
         chk("t4_m_addr",   m_address0, 64'h0080);
         tick();
      end
      chk("t4_m_writeM_done", m_writeM0, 0);
      chk("t4_m_writeM_f1",   m_writeM1, 0);
      chk("t4_d_ack",   d_ack0, 1);
      chk("t4_i_rdata", i_rdata0, 0);
      chk("t4_d_rdata", d_rdata0, 64'hCCCC_CCCC_CCCC_CCCC);
      r_park = 1'b1;
      #1;
      chk("t4_bus_done", m_data0, 64'h5A5A_5A5A_5A5A_5A5A);
      r_park   = 1'b0;
      d_writeM = 1'b0;
      tick();
      chk("t4_d_ack_off", d_ack0, 0);

      // I request squashed two cycles into BUSY
      r_mem_val = 64'h7777_0000_7777_0044;
      i_readM   = 1'b1;
      i_address = 16'h0044;
      tick();
      for (int k = 0; k < 4; k++) begin
         if (k == 2) i_readM = 1'b0;
         chk("t5_m_readM", m_readM0, 1);
         tick();
      end
      chk("t5_i_ack",   i_ack0, 1);
      chk("t5_i_rdata", i_rdata0, 64'h7777_0000_7777_0044);
      tick();
      chk("t5_idle_grant", grant_i0, 0);
      tick();
      chk("t5_idle_m_readM", m_readM0, 0);

      // Reset during BUSY of a D write aborts it without an ack
      d_writeM  = 1'b1;
      d_address = 16'h0090;
      d_wdata   = 64'h0123_4567_89AB_CDEF;
      tick();
      tick();
      chk("t6_busy_writeM", m_writeM0, 1);
      Reset_N = 1'b0;
      tick();
      Reset_N  = 1'b1;
      d_writeM = 1'b0;
      chk("t6_m_writeM", m_writeM0, 0);
      chk("t6_m_readM",  m_readM0, 0);
      chk("t6_grant_d",  grant_d0, 0);
      chk("t6_conflict", conflict0, 0);
      chk("t6_m_addr",   m_address0, 0);
      r_mem_val = 64'h3C3C_3C3C_3C3C_3C3C;
      r_park    = 1'b1;
      #1;
      chk("t6_bus_released", m_data0, 64'h3C3C_3C3C_3C3C_3C3C);
      r_park = 1'b0;
      for (int k = 0; k < 6; k++) begin
         chk("t6_no_d_ack", d_ack0, 0);
         chk("t6_no_strobe", m_writeM0, 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
